serial_rx: RTL and testbench

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_rx.sv | 200 ++++++++++++++++++++
 tb/tb_serial_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// Oversampled asynchronous serial receiver: 5-8 data bits, optional parity,
// one or two stop bits, single output register with sticky overrun.
module serial_rx #(
    parameter int OSR = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sdata,
    input  logic [15:0] baud_div,
    input  logic [1:0]  data_bits,
    input  logic        parity_en,
    input  logic        parity_odd,
    input  logic        two_stop,
    input  logic        rx_ready,
    input  logic        err_clr,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        parity_err,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);
    localparam int TW = $clog2(OSR);
    localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
    localparam logic [TW-1:0] T_MID  = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] T_END  = TW'(OSR - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // Bits arrive LSB first into the top of the shifter; right-justify by word length.
    function automatic logic [7:0] align_word(input logic [7:0] sh, input logic [1:0] bits);
        logic [7:0] w;
        case (bits)
            2'b00:   w = {3'b000, sh[7:3]};
            2'b01:   w = {2'b00, sh[7:2]};
            2'b10:   w = {1'b0, sh[7:1]};
            2'b11:   w = sh;
            default: w = sh;
        endcase
        return w;
    endfunction

    function automatic logic parity8(input logic [7:0] d);
        return ^d;
    endfunction

    logic        sync1_r, sync2_r, sdata_s;
    logic [15:0] div_m1_s, pcnt_r;
    logic        tick_s, mid_s, end_s, start_det_s;
    logic [TW-1:0] tcnt_r;
    state_t      state_r, state_nx_s;
    logic        shift_s, par_smp_s, stop_smp_s, last_stop_s, last_bit_s;
    logic [7:0]  shreg_r;
    logic [2:0]  bcnt_r;
    logic [1:0]  bits_r;
    logic        par_en_r, par_odd_r, two_stop_r;
    logic        perr_r, ferr_r, done_r;

    assign sdata_s     = sync2_r;
    assign div_m1_s    = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;
    assign tick_s      = (pcnt_r >= div_m1_s);
    assign mid_s       = tick_s && (tcnt_r == T_MID);
    assign end_s       = tick_s && (tcnt_r == T_END);
    assign start_det_s = (state_r == IDLE) && !sdata_s;
    assign last_bit_s  = (bcnt_r == (3'd4 + {1'b0, bits_r}));

    // Two-flop synchronizer on the line, idle-high reset value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= sdata;
            sync2_r <= sync1_r;
        end
    end

    // Baud prescaler and oversample tick counter, both restarted on a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_r <= 16'd0;
            tcnt_r <= T_ZERO;
        end else begin
            if (start_det_s || tick_s) pcnt_r <= 16'd0;
            else                       pcnt_r <= pcnt_r + 16'd1;
            if (start_det_s || ((state_r == START) && mid_s)) tcnt_r <= T_ZERO;
            else if (tick_s && (state_r != IDLE))             tcnt_r <= tcnt_r + TW'(1);
            else                                              tcnt_r <= tcnt_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nx_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE:    state_nx_s = sdata_s ? IDLE : START;
            START:   if (mid_s) state_nx_s = sdata_s ? IDLE : DATA;
                     else       state_nx_s = START;
            DATA:    if (end_s && last_bit_s) state_nx_s = par_en_r ? PARITY : STOP1;
                     else                     state_nx_s = DATA;
            PARITY:  state_nx_s = end_s ? STOP1 : PARITY;
            STOP1:   if (end_s) state_nx_s = two_stop_r ? STOP2 : IDLE;
                     else       state_nx_s = STOP1;
            STOP2:   state_nx_s = end_s ? IDLE : STOP2;
            default: state_nx_s = IDLE;
        endcase
    end

    // FSM outputs: per-state sample strobes.
    always_comb begin
        shift_s     = 1'b0;
        par_smp_s   = 1'b0;
        stop_smp_s  = 1'b0;
        last_stop_s = 1'b0;
        case (state_r)
            DATA:    shift_s = end_s;
            PARITY:  par_smp_s = end_s;
            STOP1:   begin
                stop_smp_s  = end_s;
                last_stop_s = end_s && !two_stop_r;
            end
            STOP2:   begin
                stop_smp_s  = end_s;
                last_stop_s = end_s;
            end
            default: shift_s = 1'b0;
        endcase
    end

    // Frame datapath: config snapshot, shifter, error accumulation, completion strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bits_r     <= 2'b00;
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            two_stop_r <= 1'b0;
            shreg_r    <= 8'h00;
            bcnt_r     <= 3'd0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (start_det_s) begin
                bits_r     <= data_bits;
                par_en_r   <= parity_en;
                par_odd_r  <= parity_odd;
                two_stop_r <= two_stop;
                shreg_r    <= 8'h00;
                bcnt_r     <= 3'd0;
                perr_r     <= 1'b0;
                ferr_r     <= 1'b0;
            end else if (shift_s) begin
                shreg_r <= {sdata_s, shreg_r[7:1]};
                bcnt_r  <= bcnt_r + 3'd1;
            end else if (par_smp_s) begin
                perr_r <= ((parity8(shreg_r) ^ sdata_s) != par_odd_r);
            end else if (stop_smp_s) begin
                ferr_r <= ferr_r | ~sdata_s;
            end
            done_r <= last_stop_s;
        end
    end

    // Output register with ready/valid hold and sticky overrun (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (done_r && (!rx_valid || rx_ready)) begin
                rx_data    <= align_word(shreg_r, bits_r);
                parity_err <= perr_r;
                frame_err  <= ferr_r;
                rx_valid   <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (done_r && rx_valid && !rx_ready) overrun <= 1'b1;
            else if (err_clr)                    overrun <= 1'b0;
            busy <= (state_nx_s != IDLE);
        end
    end
endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: frames driven at baud_div=4 (64 clk per bit).
module tb_serial_rx;
    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sdata = 1'b1;
    logic [15:0] baud_div = 16'd4;
    logic [1:0] data_bits = 2'b11;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic       rx_ready = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overrun, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rise_cyc = 0;
    int rises = 0;
    int rises0 = 0;
    logic prev_v = 1'b0;

    serial_rx #(.OSR(16)) dut (
        .clk(clk), .rst(rst), .sdata(sdata), .baud_div(baud_div),
        .data_bits(data_bits), .parity_en(parity_en), .parity_odd(parity_odd),
        .two_stop(two_stop), .rx_ready(rx_ready), .err_clr(err_clr),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !prev_v) begin
            rises = rises + 1;
            rise_cyc = cyc;
        end
        prev_v = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic hold_bit(input logic v, input int n);
        sdata = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic has_par,
                              input logic pbit, input int nstop, input logic stop2_val);
        @(negedge clk);
        start_cyc = cyc;
        hold_bit(1'b0, BIT_CLK);
        for (int i = 0; i < nbits; i++) hold_bit(d[i], BIT_CLK);
        if (has_par) hold_bit(pbit, BIT_CLK);
        hold_bit(1'b1, BIT_CLK);
        if (nstop == 2) begin
            hold_bit(stop2_val, BIT_CLK * 3 / 4);
            hold_bit(1'b1, BIT_CLK / 4);
        end
    endtask

    task automatic consume(input string tag);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk(tag, 32'(rx_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_errs", 32'({parity_err, frame_err}), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5 with latency window
        rises0 = rises;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("a5_rises", 32'(rises - rises0), 32'd1);
        chk("a5_latency", 32'((rise_cyc - start_cyc >= 608) && (rise_cyc - start_cyc <= 612)), 32'd1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_errs", 32'({parity_err, frame_err}), 32'd0);
        chk("a5_busy", 32'(busy), 32'd0);
        consume("a5_consume");

        // false start: 20 clk low pulse
        rises0 = rises;
        @(negedge clk);
        sdata = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        sdata = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_busy_lo", 32'(busy), 32'd0);
        chk("glitch_novalid", 32'(rises - rises0), 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("3c_data", 32'(rx_data), 32'h3C);
        chk("3c_valid", 32'(rx_valid), 32'd1);
        consume("3c_consume");

        // 7E1 0x41: parity bit 1 is wrong, parity bit 0 is right
        data_bits = 2'b10;
        parity_en = 1'b1;
        parity_odd = 1'b0;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1);
        chk("7e1_data_bad", 32'(rx_data), 32'h41);
        chk("7e1_perr1", 32'(parity_err), 32'd1);
        consume("7e1_consume1");
        send_frame(8'h41, 7, 1'b1, 1'b0, 1, 1'b1);
        chk("7e1_data_ok", 32'(rx_data), 32'h41);
        chk("7e1_perr0", 32'(parity_err), 32'd0);
        consume("7e1_consume2");

        // 5N1: shortest word, unused MSBs zero
        data_bits = 2'b00;
        parity_en = 1'b0;
        send_frame(8'hF3, 5, 1'b0, 1'b0, 1, 1'b1);
        chk("5n1_data", 32'(rx_data), 32'h13);
        consume("5n1_consume");

        // 8N2 0x5A with bad second stop bit
        data_bits = 2'b11;
        two_stop = 1'b1;
        send_frame(8'h5A, 8, 1'b0, 1'b0, 2, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        chk("8n2_data", 32'(rx_data), 32'h5A);
        chk("8n2_ferr", 32'(frame_err), 32'd1);
        chk("8n2_perr", 32'(parity_err), 32'd0);
        consume("8n2_consume");
        two_stop = 1'b0;

        // overrun: second word dropped while first is held
        send_frame(8'h11, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("ovr_data", 32'(rx_data), 32'h11);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);
        consume("ovr_consume");

        // reset in the middle of data bit 3 of 0xFF
        rises0 = rises;
        @(negedge clk);
        hold_bit(1'b0, BIT_CLK);
        hold_bit(1'b1, 3 * BIT_CLK + BIT_CLK / 2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (6 * BIT_CLK) @(negedge clk);
        chk("mid_rst_noword", 32'(rises - rises0), 32'd0);
        chk("mid_rst_idle", 32'(busy), 32'd0);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1, 1'b1);
        chk("0f_data", 32'(rx_data), 32'h0F);
        chk("0f_valid", 32'(rx_valid), 32'd1);
        chk("0f_errs", 32'({parity_err, frame_err}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
